imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
Write-side sequencer for the 16x16 instruction-memory register files (high and low halves). It accepts a stream of 16-bit instruction words over a valid/ready handshake and drives the IMEM write port (WRITE_SELECT, WRITE_ENABLE, IMEM_INPUT) at consecutive addresses starting at 0. It then reads the loaded range back through READ_SELECT/IMEM_OUTPUT and checks it against a running checksum. It sits between the program-entry source (switch/serial front end) and one IMEM half.

Parameters:
DATA_W, 16, instruction word width; must match the IMEM bus width.
ADDR_W, 4, IMEM address width; depth = 2**ADDR_W = 16.
VERIFY_EN, 1, 1 = run the readback checksum pass after loading; 0 = go straight to DONE after the last write.

Ports:
CLOCK  input  1  system clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  one-cycle pulse that begins a load; accepted in IDLE, DONE or ERROR only.
LOAD_COUNT  input  ADDR_W+1  number of words to load, 1..16; 0 is treated as 16; sampled on the accepted START.
WORD_IN  input  DATA_W  instruction word from the source.
WORD_VALID  input  1  WORD_IN is valid.
WORD_READY  output  1  loader accepts WORD_IN this cycle.
WRITE_ENABLE  output  1  IMEM write strobe.
WRITE_SELECT  output  ADDR_W  IMEM write address.
IMEM_INPUT  output  DATA_W  IMEM write data.
READ_SELECT  output  ADDR_W  IMEM read address, used during verify.
IMEM_OUTPUT  input  DATA_W  combinational IMEM read data.
BUSY  output  1  high in LOAD, FLUSH and VERIFY.
DONE  output  1  sticky success flag.
VERIFY_ERROR  output  1  sticky checksum-mismatch flag.
WORD_COUNT  output  ADDR_W+1  number of words accepted so far.

Behaviour:
- Reset: state = INIT. All outputs are 0: WORD_READY, WRITE_ENABLE, WRITE_SELECT, IMEM_INPUT, READ_SELECT, BUSY, DONE, VERIFY_ERROR, WORD_COUNT. Checksum registers are cleared.
- INIT: lasts exactly 1 cycle, then moves to IDLE. This covers the IMEM preload cycle after reset. START is ignored in INIT.
- IDLE, DONE, ERROR on START:
  - Latch the target count N; 0 maps to 16.
  - Clear WORD_COUNT, the load checksum, the readback checksum, DONE and VERIFY_ERROR.
  - Move to LOAD on the next cycle.
- START in any other state is ignored.
- LOAD:
  - WORD_READY = 1 while WORD_COUNT < N.
  - A word is accepted when WORD_VALID & WORD_READY. Acceptance in cycle k gives, in cycle k+1, a registered single-cycle write: WRITE_ENABLE = 1, WRITE_SELECT = accepted index, IMEM_INPUT = word.
  - One word per cycle is sustained; back-to-back writes keep WRITE_ENABLE high continuously.
  - On each acceptance: WORD_COUNT += 1 and load checksum += word (mod 2**DATA_W).
  - The acceptance that makes WORD_COUNT = N moves the FSM to FLUSH.
- FLUSH (1 cycle): the last write is on the port. WORD_READY = 0. Next state is VERIFY if VERIFY_EN = 1, else DONE.
- WRITE_ENABLE is 0 in every cycle that does not follow an acceptance.
- VERIFY:
  - READ_SELECT steps 0, 1, ..., N-1, one address per cycle. Each cycle, IMEM_OUTPUT is added to the readback checksum (mod 2**DATA_W).
  - After address N-1 is summed, go to DONE if the checksums are equal; otherwise go to ERROR with VERIFY_ERROR = 1.
  - READ_SELECT returns to 0 outside VERIFY.
- DONE: DONE = 1.
- ERROR: VERIFY_ERROR = 1.
- Both flags hold until the next accepted START or RESET.
- WORD_VALID is ignored outside LOAD. WORD_IN is never sampled while WORD_READY = 0.
- RESET asserted mid-load or mid-verify aborts immediately. All outputs take reset values on the next edge. A write that was in flight is dropped: WRITE_ENABLE = 0 in the cycle after RESET is sampled.
- Checksum overflow wraps silently.

Test Plan:
- Reset release, START asserted in the first cycle -> ignored (INIT). START one cycle later with LOAD_COUNT = 3, words 0x1111, 0x2222, 0x3333 valid every cycle -> WRITE_ENABLE high for 3 consecutive cycles at addresses 0, 1, 2. With a matching IMEM model, DONE = 1 and VERIFY_ERROR = 0 after 3 verify cycles.
- LOAD_COUNT = 0, 16 words 0xFFFF with gaps of random WORD_VALID idle cycles -> 16 writes at addresses 0..15, no write in idle cycles, load checksum 0xFFF0, DONE = 1.
- IMEM model corrupts address 1 (returns 0x2223) -> VERIFY_ERROR = 1, DONE = 0. A new START clears VERIFY_ERROR.
- VERIFY_EN = 0, LOAD_COUNT = 2 -> DONE asserts the cycle after FLUSH. READ_SELECT stays 0 throughout.
- RESET pulsed after the 2nd of 4 accepted words -> WRITE_ENABLE = 0 the next cycle, all outputs 0, FSM in INIT. START is accepted only from IDLE afterwards.
- START pulsed while in LOAD -> ignored. WORD_COUNT and the address sequence are unaffected.

Source files
------------

// File: rtl/imem_program_loader.sv
// imem_program_loader: write-side sequencer for one 16x16 IMEM half.
// Accepts instruction words over a valid/ready handshake and writes them to consecutive
// addresses starting at 0. It then optionally reads the loaded range back and compares
// a readback checksum against the checksum accumulated while loading.
module imem_program_loader #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter bit          VERIFY_EN = 1'b1
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              START,
   input  logic [ADDR_W:0]   LOAD_COUNT,
   input  logic [DATA_W-1:0] WORD_IN,
   input  logic              WORD_VALID,
   output logic              WORD_READY,
   output logic              WRITE_ENABLE,
   output logic [ADDR_W-1:0] WRITE_SELECT,
   output logic [DATA_W-1:0] IMEM_INPUT,
   output logic [ADDR_W-1:0] READ_SELECT,
   input  logic [DATA_W-1:0] IMEM_OUTPUT,
   output logic              BUSY,
   output logic              DONE,
   output logic              VERIFY_ERROR,
   output logic [ADDR_W:0]   WORD_COUNT
);

   // Full memory depth, expressed in the count width (one bit wider than an address).
   localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StLoad,
      StFlush,
      StVerify,
      StDone,
      StError
   } state_e;

   state_e              state_q;
   logic [ADDR_W:0]     target_q;
   logic [ADDR_W:0]     count_q;
   logic [DATA_W-1:0]   sum_load_q;
   logic [DATA_W-1:0]   sum_read_q;
   logic                ready_q;
   logic                we_q;
   logic [ADDR_W-1:0]   wsel_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [ADDR_W-1:0]   rsel_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;

   logic                accept;
   logic [ADDR_W:0]     count_inc;
   logic [ADDR_W:0]     target_d;
   logic [DATA_W-1:0]   sum_read_inc;
   logic                verify_last;

   // Handshake, counter and checksum helpers derived from current state.
   always_comb begin
      accept       = WORD_VALID & ready_q;
      count_inc    = count_q + 1'b1;
      sum_read_inc = sum_read_q + IMEM_OUTPUT;
      verify_last  = ({1'b0, rsel_q} == (target_q - 1'b1));
      // A count of 0, or anything beyond the memory depth, loads the whole memory.
      if (LOAD_COUNT == '0 || LOAD_COUNT > Depth) begin
         target_d = Depth;
      end else begin
         target_d = LOAD_COUNT;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q    <= StInit;
         target_q   <= '0;
         count_q    <= '0;
         sum_load_q <= '0;
         sum_read_q <= '0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         wsel_q     <= '0;
         wdata_q    <= '0;
         rsel_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         // The write strobe lives only in the cycle right after an acceptance.
         we_q <= 1'b0;
         unique case (state_q)
            StInit: begin
               // Covers the IMEM preload cycle; START is not looked at here.
               state_q <= StIdle;
            end
            StIdle, StDone, StError: begin
               if (START) begin
                  target_q   <= target_d;
                  count_q    <= '0;
                  sum_load_q <= '0;
                  sum_read_q <= '0;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  ready_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= StLoad;
               end
            end
            StLoad: begin
               if (accept) begin
                  we_q       <= 1'b1;
                  wsel_q     <= count_q[ADDR_W-1:0];
                  wdata_q    <= WORD_IN;
                  count_q    <= count_inc;
                  sum_load_q <= sum_load_q + WORD_IN;
                  if (count_inc == target_q) begin
                     ready_q <= 1'b0;
                     state_q <= StFlush;
                  end
               end
            end
            StFlush: begin
               // The final write is on the port this cycle.
               if (VERIFY_EN) begin
                  rsel_q  <= '0;
                  state_q <= StVerify;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StVerify: begin
               sum_read_q <= sum_read_inc;
               if (verify_last) begin
                  rsel_q <= '0;
                  busy_q <= 1'b0;
                  if (sum_read_inc == sum_load_q) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= StError;
                  end
               end else begin
                  rsel_q <= rsel_q + 1'b1;
               end
            end
            default: begin
               state_q <= StInit;
            end
         endcase
      end
   end

   assign WORD_READY   = ready_q;
   assign WRITE_ENABLE = we_q;
   assign WRITE_SELECT = wsel_q;
   assign IMEM_INPUT   = wdata_q;
   assign READ_SELECT  = rsel_q;
   assign BUSY         = busy_q;
   assign DONE         = done_q;
   assign VERIFY_ERROR = err_q;
   assign WORD_COUNT   = count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader: table-driven first load plus directed corner cases.
module tb_imem_program_loader;

   localparam int DW = 16;
   localparam int AW = 4;

   logic          CLOCK = 1'b0;
   logic          RESET;
   logic          START;
   logic          START2;
   logic [AW:0]   LOAD_COUNT;
   logic [DW-1:0] WORD_IN;
   logic          WORD_VALID;

   logic          ready, we, busy, done, verr;
   logic [AW-1:0] ws, rs;
   logic [DW-1:0] wdata, imem_out;
   logic [AW:0]   wc;

   logic          ready2, we2, busy2, done2, verr2;
   logic [AW-1:0] ws2, rs2;
   logic [DW-1:0] wdata2;
   logic [DW-1:0] imem_out2;
   logic [AW:0]   wc2;

   logic [DW-1:0] mem [16];
   logic          corrupt;

   int errors = 0;
   int checks = 0;

   always #5 CLOCK = ~CLOCK;

   imem_program_loader #(.DATA_W(DW), .ADDR_W(AW), .VERIFY_EN(1'b1)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .START(START), .LOAD_COUNT(LOAD_COUNT),
      .WORD_IN(WORD_IN), .WORD_VALID(WORD_VALID), .WORD_READY(ready),
      .WRITE_ENABLE(we), .WRITE_SELECT(ws), .IMEM_INPUT(wdata), .READ_SELECT(rs),
      .IMEM_OUTPUT(imem_out), .BUSY(busy), .DONE(done), .VERIFY_ERROR(verr),
      .WORD_COUNT(wc)
   );

   imem_program_loader #(.DATA_W(DW), .ADDR_W(AW), .VERIFY_EN(1'b0)) dut_nv (
      .CLOCK(CLOCK), .RESET(RESET), .START(START2), .LOAD_COUNT(LOAD_COUNT),
      .WORD_IN(WORD_IN), .WORD_VALID(WORD_VALID), .WORD_READY(ready2),
      .WRITE_ENABLE(we2), .WRITE_SELECT(ws2), .IMEM_INPUT(wdata2), .READ_SELECT(rs2),
      .IMEM_OUTPUT(imem_out2), .BUSY(busy2), .DONE(done2), .VERIFY_ERROR(verr2),
      .WORD_COUNT(wc2)
   );

   // IMEM model: synchronous write, combinational read, optional corruption of address 1.
   always @(posedge CLOCK) begin
      if (RESET) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (we) begin
         mem[ws] <= wdata;
      end
   end

   assign imem_out  = (corrupt && rs == 4'd1) ? 16'h2223 : mem[rs];
   assign imem_out2 = 16'h0000;

   typedef struct {
      logic          rst;
      logic          start;
      logic [AW:0]   lc;
      logic          valid;
      logic [DW-1:0] word;
      logic          e_ready;
      logic          e_we;
      logic [AW-1:0] e_ws;
      logic [DW-1:0] e_data;
      logic [AW-1:0] e_rs;
      logic          e_busy;
      logic          e_done;
      logic          e_err;
      logic [AW:0]   e_cnt;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive inputs at the falling edge, clock once, return at the next falling edge.
   task automatic step(input logic r, input logic s, input logic [AW:0] lc, input logic v,
                       input logic [DW-1:0] w);
      RESET      = r;
      START      = s;
      LOAD_COUNT = lc;
      WORD_VALID = v;
      WORD_IN    = w;
      @(posedge CLOCK);
      @(negedge CLOCK);
   endtask

   task automatic wait_idle(input string name, output int n);
      n = 0;
      while (busy && n < 40) begin
         step(1'b0, 1'b0, 5'd0, 1'b0, 16'h0000);
         n++;
      end
      chk({name, ".timeout"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int  n;
      int  gap;
      logic all_ff;

      corrupt = 1'b0;
      START2  = 1'b0;

      //              rst   start lc    valid word      rdy   we    ws    data      rs    busy  done  err   cnt
      tbl[0]  = '{1'b1, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0};
      tbl[1]  = '{1'b0, 1'b1, 5'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0};
      tbl[2]  = '{1'b0, 1'b1, 5'd3, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[3]  = '{1'b0, 1'b0, 5'd0, 1'b1, 16'h1111, 1'b1, 1'b1, 4'd0, 16'h1111, 4'd0, 1'b1, 1'b0, 1'b0, 5'd1};
      tbl[4]  = '{1'b0, 1'b0, 5'd0, 1'b1, 16'h2222, 1'b1, 1'b1, 4'd1, 16'h2222, 4'd0, 1'b1, 1'b0, 1'b0, 5'd2};
      tbl[5]  = '{1'b0, 1'b0, 5'd0, 1'b1, 16'h3333, 1'b0, 1'b1, 4'd2, 16'h3333, 4'd0, 1'b1, 1'b0, 1'b0, 5'd3};
      tbl[6]  = '{1'b0, 1'b0, 5'd0, 1'b1, 16'h4444, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 5'd3};
      tbl[7]  = '{1'b0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0, 5'd3};
      tbl[8]  = '{1'b0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 5'd3};
      tbl[9]  = '{1'b0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 5'd3};
      tbl[10] = '{1'b0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 5'd3};

      // Reset, START ignored in INIT, three-word load with verify.
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].rst, tbl[i].start, tbl[i].lc, tbl[i].valid, tbl[i].word);
         chk($sformatf("r%0d.ready", i), {31'b0, ready}, {31'b0, tbl[i].e_ready});
         chk($sformatf("r%0d.we", i), {31'b0, we}, {31'b0, tbl[i].e_we});
         if (tbl[i].rst || tbl[i].e_we) begin
            chk($sformatf("r%0d.wsel", i), {28'b0, ws}, {28'b0, tbl[i].e_ws});
            chk($sformatf("r%0d.data", i), {16'b0, wdata}, {16'b0, tbl[i].e_data});
         end
         chk($sformatf("r%0d.rsel", i), {28'b0, rs}, {28'b0, tbl[i].e_rs});
         chk($sformatf("r%0d.busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
         chk($sformatf("r%0d.done", i), {31'b0, done}, {31'b0, tbl[i].e_done});
         chk($sformatf("r%0d.verr", i), {31'b0, verr}, {31'b0, tbl[i].e_err});
         chk($sformatf("r%0d.count", i), {27'b0, wc}, {27'b0, tbl[i].e_cnt});
      end

      // LOAD_COUNT = 0 loads 16 words of 0xFFFF with idle gaps.
      step(1'b0, 1'b1, 5'd0, 1'b0, 16'hDEAD);
      chk("t2.busy", {31'b0, busy}, 32'd1);
      chk("t2.done_cleared", {31'b0, done}, 32'd0);
      chk("t2.count_cleared", {27'b0, wc}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         gap = (i == 5) ? 2 : int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b0, 5'd0, 1'b0, 16'hDEAD);
            chk($sformatf("t2.gap%0d.we", i), {31'b0, we}, 32'd0);
         end
         step(1'b0, 1'b0, 5'd0, 1'b1, 16'hFFFF);
         chk($sformatf("t2.w%0d.we", i), {31'b0, we}, 32'd1);
         chk($sformatf("t2.w%0d.wsel", i), {28'b0, ws}, i);
         chk($sformatf("t2.w%0d.count", i), {27'b0, wc}, i + 1);
      end
      chk("t2.ready_flush", {31'b0, ready}, 32'd0);
      wait_idle("t2", n);
      chk("t2.verify_cycles", n, 32'd17);
      chk("t2.done", {31'b0, done}, 32'd1);
      chk("t2.verr", {31'b0, verr}, 32'd0);
      chk("t2.load_sum", {16'b0, dut.sum_load_q}, 32'hFFF0);
      all_ff = 1'b1;
      for (int i = 0; i < 16; i++) if (mem[i] !== 16'hFFFF) all_ff = 1'b0;
      chk("t2.mem_all_ffff", {31'b0, all_ff}, 32'd1);

      // Corrupted readback at address 1 raises VERIFY_ERROR; a new START clears it.
      corrupt = 1'b1;
      step(1'b0, 1'b1, 5'd3, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'h1111);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'h2222);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'h3333);
      wait_idle("t3", n);
      chk("t3.verr", {31'b0, verr}, 32'd1);
      chk("t3.done", {31'b0, done}, 32'd0);
      corrupt = 1'b0;
      step(1'b0, 1'b1, 5'd1, 1'b0, 16'h0000);
      chk("t3.verr_cleared", {31'b0, verr}, 32'd0);
      chk("t3.restart_busy", {31'b0, busy}, 32'd1);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'h5A5A);
      wait_idle("t3b", n);
      chk("t3b.done", {31'b0, done}, 32'd1);

      // VERIFY_EN = 0: DONE the cycle after FLUSH, READ_SELECT stays 0.
      START2 = 1'b1;
      step(1'b0, 1'b0, 5'd2, 1'b0, 16'h0000);
      START2 = 1'b0;
      chk("t4.busy", {31'b0, busy2}, 32'd1);
      chk("t4.rsel0", {28'b0, rs2}, 32'd0);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'hAAAA);
      chk("t4.w0.we", {31'b0, we2}, 32'd1);
      chk("t4.w0.wsel", {28'b0, ws2}, 32'd0);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'hBBBB);
      chk("t4.w1.wsel", {28'b0, ws2}, 32'd1);
      chk("t4.flush.done", {31'b0, done2}, 32'd0);
      chk("t4.flush.busy", {31'b0, busy2}, 32'd1);
      chk("t4.rsel1", {28'b0, rs2}, 32'd0);
      step(1'b0, 1'b0, 5'd0, 1'b0, 16'h0000);
      chk("t4.done", {31'b0, done2}, 32'd1);
      chk("t4.busy_low", {31'b0, busy2}, 32'd0);
      chk("t4.rsel2", {28'b0, rs2}, 32'd0);
      chk("t4.verr", {31'b0, verr2}, 32'd0);

      // RESET after the second of four accepted words aborts everything.
      step(1'b0, 1'b1, 5'd4, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'h0101);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'h0202);
      chk("t5.w1.we", {31'b0, we}, 32'd1);
      chk("t5.w1.wsel", {28'b0, ws}, 32'd1);
      step(1'b1, 1'b0, 5'd0, 1'b1, 16'h0303);
      chk("t5.rst.we", {31'b0, we}, 32'd0);
      chk("t5.rst.ready", {31'b0, ready}, 32'd0);
      chk("t5.rst.wsel", {28'b0, ws}, 32'd0);
      chk("t5.rst.data", {16'b0, wdata}, 32'd0);
      chk("t5.rst.rsel", {28'b0, rs}, 32'd0);
      chk("t5.rst.busy", {31'b0, busy}, 32'd0);
      chk("t5.rst.done", {31'b0, done}, 32'd0);
      chk("t5.rst.verr", {31'b0, verr}, 32'd0);
      chk("t5.rst.count", {27'b0, wc}, 32'd0);
      step(1'b0, 1'b1, 5'd1, 1'b0, 16'h0000);
      chk("t5.init_ignores_start", {31'b0, busy}, 32'd0);
      step(1'b0, 1'b1, 5'd1, 1'b0, 16'h0000);
      chk("t5.idle_accepts_start", {31'b0, busy}, 32'd1);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'h0707);
      chk("t5.w0.wsel", {28'b0, ws}, 32'd0);
      wait_idle("t5", n);
      chk("t5.done", {31'b0, done}, 32'd1);

      // START during LOAD is ignored.
      step(1'b0, 1'b1, 5'd3, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'h1000);
      step(1'b0, 1'b1, 5'd5, 1'b1, 16'h2000);
      chk("t6.count", {27'b0, wc}, 32'd2);
      chk("t6.wsel", {28'b0, ws}, 32'd1);
      chk("t6.we", {31'b0, we}, 32'd1);
      step(1'b0, 1'b0, 5'd0, 1'b1, 16'h3000);
      chk("t6.count3", {27'b0, wc}, 32'd3);
      chk("t6.wsel2", {28'b0, ws}, 32'd2);
      chk("t6.ready_flush", {31'b0, ready}, 32'd0);
      wait_idle("t6", n);
      chk("t6.done", {31'b0, done}, 32'd1);
      chk("t6.verr", {31'b0, verr}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
